vs_spi_responder: RTL and testbench

//  SPI responder for the MP3 decoder serial interface: emulates the VS10xx side. Receives SCI

---
 rtl/vs_spi_responder.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_vs_spi_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vs_spi_responder.sv
// VS10xx-style SPI responder: SCI register file, SDI word FIFO with DREQ flow control.
// Define SCI_READ_EN to enable SCI read (op 0x03) with data shifted out on so.
module vs_spi_responder #(
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter int unsigned DREQ_THRESH = 16,
  parameter int unsigned BOOT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xrset,
  input  logic        xcs,
  input  logic        xdcs,
  input  logic        sclk,
  input  logic        si,
  output logic        dreq,
  output logic        so,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [15:0] mode,
  output logic [15:0] vol,
  output logic        frame_err,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BOOT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCI  = 2'd1;
  localparam logic [1:0] S_SDI  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  // Input synchronisers and SCLK edge history
  logic [1:0] xcs_sq, xdcs_sq, sclk_sq, si_sq, xrset_sq;
  logic       sclk_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xcs_sq      <= 2'b11;
      xdcs_sq     <= 2'b11;
      sclk_sq     <= 2'b00;
      si_sq       <= 2'b00;
      xrset_sq    <= 2'b11;
      sclk_prev_q <= 1'b0;
    end else begin
      xcs_sq      <= {xcs_sq[0], xcs};
      xdcs_sq     <= {xdcs_sq[0], xdcs};
      sclk_sq     <= {sclk_sq[0], sclk};
      si_sq       <= {si_sq[0], si};
      xrset_sq    <= {xrset_sq[0], xrset};
      sclk_prev_q <= sclk_sq[1];
    end
  end

  logic xcs_s, xdcs_s, si_s, hard_rst, sclk_rise;
  assign xcs_s     = xcs_sq[1];
  assign xdcs_s    = xdcs_sq[1];
  assign si_s      = si_sq[1];
  assign hard_rst  = ~xrset_sq[1];
  assign sclk_rise = sclk_sq[1] & ~sclk_prev_q;

  // Frame FSM: bit counter, shift register, conflict tracking
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;
  logic        conflict_q, conflict_d;
  logic        frame_err_q, frame_err_d;
  logic        sci_done_q, sci_done_d;
  logic        sdi_done_q, sdi_done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    conflict_d  = conflict_q;
    frame_err_d = 1'b0;
    sci_done_d  = 1'b0;
    sdi_done_d  = 1'b0;
    if (xdcs_s) conflict_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 5'd0;
        if (!xcs_s) begin
          state_d = S_SCI;
          if (!xdcs_s) begin
            conflict_d  = 1'b1;
            frame_err_d = 1'b1;
          end
        end else if (!xdcs_s) begin
          state_d = S_SDI;
        end
      end
      S_SCI: begin
        if (xcs_s) begin
          state_d     = xdcs_s ? S_IDLE : S_WAIT;
          frame_err_d = (cnt_q != 5'd0);
          cnt_d       = 5'd0;
        end else begin
          if (!xdcs_s && !conflict_q) begin
            conflict_d  = 1'b1;
            frame_err_d = 1'b1;
          end
          if (sclk_rise) begin
            shift_d    = {shift_q[30:0], si_s};
            cnt_d      = cnt_q + 5'd1;
            sci_done_d = (cnt_q == 5'd31);
          end
        end
      end
      S_SDI: begin
        if (!xcs_s) begin
          // SCI pre-empts an SDI window; its partial word is dropped
          state_d     = S_SCI;
          cnt_d       = 5'd0;
          conflict_d  = 1'b1;
          frame_err_d = 1'b1;
        end else if (xdcs_s) begin
          state_d     = S_IDLE;
          frame_err_d = (cnt_q[3:0] != 4'd0);
          cnt_d       = 5'd0;
        end else if (sclk_rise) begin
          shift_d    = {shift_q[30:0], si_s};
          cnt_d      = {1'b0, cnt_q[3:0] + 4'd1};
          sdi_done_d = (cnt_q[3:0] == 4'd15);
        end
      end
      default: begin
        cnt_d = 5'd0;
        if (!xcs_s)      state_d = S_SCI;
        else if (xdcs_s) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      shift_q     <= 32'd0;
      conflict_q  <= 1'b0;
      frame_err_q <= 1'b0;
      sci_done_q  <= 1'b0;
      sdi_done_q  <= 1'b0;
    end else if (hard_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      shift_q     <= 32'd0;
      conflict_q  <= 1'b0;
      frame_err_q <= 1'b0;
      sci_done_q  <= 1'b0;
      sdi_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      conflict_q  <= conflict_d;
      frame_err_q <= frame_err_d;
      sci_done_q  <= sci_done_d;
      sdi_done_q  <= sdi_done_d;
    end
  end

  // SCI command decode, one cycle after the 32nd bit
  logic [7:0]  sci_op, sci_addr;
  logic [15:0] sci_data;
  logic        write_c, soft_rst;
  assign sci_op   = shift_q[31:24];
  assign sci_addr = shift_q[23:16];
  assign sci_data = shift_q[15:0];
  assign write_c  = sci_done_q && (sci_op == 8'h02) && (sci_addr[7:4] == 4'd0);
  assign soft_rst = write_c && (sci_addr[3:0] == 4'd0) && sci_data[2];

  logic [15:0] regs_q [16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= (i == 0) ? 16'h0800 : 16'h0000;
    end else if (hard_rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= (i == 0) ? 16'h0800 : 16'h0000;
    end else if (soft_rst) begin
      for (int i = 1; i < 16; i++) regs_q[i] <= 16'h0000;
      regs_q[0] <= sci_data & ~16'h0004;
    end else if (write_c) begin
      regs_q[sci_addr[3:0]] <= sci_data;
    end
  end

  // SDI FIFO; a pop frees a slot for a push in the same cycle
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full_c, pop_c, push_c;
  logic [BW-1:0] boot_q, boot_d;
  logic          dreq_q, dreq_d;

  assign count_q = wp_q - rp_q;
  assign full_c  = (count_q == CW'(FIFO_DEPTH));
  assign pop_c   = (wp_q != rp_q) && data_ready;
  assign push_c  = !hard_rst && !soft_rst && sdi_done_q && (!full_c || pop_c);

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    overflow_d = overflow_q;
    boot_d     = boot_q;
    if (hard_rst) begin
      wp_d       = '0;
      rp_d       = '0;
      overflow_d = 1'b0;
      boot_d     = BW'(BOOT_CYCLES);
    end else if (soft_rst) begin
      wp_d   = '0;
      rp_d   = '0;
      boot_d = BW'(BOOT_CYCLES);
    end else begin
      if (pop_c)  rp_d = rp_q + 1'b1;
      if (push_c) wp_d = wp_q + 1'b1;
      else if (sdi_done_q) overflow_d = 1'b1;
      if (boot_q != '0) boot_d = boot_q - 1'b1;
    end
    count_d = wp_d - rp_d;
    dreq_d  = (boot_d == '0) && (count_d <= CW'(FIFO_DEPTH - DREQ_THRESH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      overflow_q <= 1'b0;
      boot_q     <= BW'(BOOT_CYCLES);
      dreq_q     <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      overflow_q <= overflow_d;
      boot_q     <= boot_d;
      dreq_q     <= dreq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wp_q[AW-1:0]] <= sci_data;
  end

`ifdef SCI_READ_EN
  // Read data: first bit presented after the address, later bits on SCLK falling edges
  logic        sclk_fall;
  logic [15:0] rd_q, rd_d;
  logic        rd_act_q, rd_act_d;
  logic        so_q, so_d;
  assign sclk_fall = ~sclk_sq[1] & sclk_prev_q;

  always_comb begin
    rd_d     = rd_q;
    rd_act_d = rd_act_q;
    so_d     = so_q;
    if (soft_rst || state_q != S_SCI) begin
      rd_act_d = 1'b0;
      so_d     = 1'b0;
    end else if (sclk_rise && cnt_q == 5'd15) begin
      rd_act_d = (shift_d[15:8] == 8'h03);
      rd_d     = (shift_d[7:4] == 4'd0) ? regs_q[shift_d[3:0]] : 16'h0000;
      so_d     = rd_act_d && rd_d[15];
    end else if (sclk_fall && rd_act_q && cnt_q > 5'd16) begin
      so_d = rd_q[14];
      rd_d = {rd_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= 16'h0000;
      rd_act_q <= 1'b0;
      so_q     <= 1'b0;
    end else if (hard_rst) begin
      rd_q     <= 16'h0000;
      rd_act_q <= 1'b0;
      so_q     <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      rd_act_q <= rd_act_d;
      so_q     <= so_d;
    end
  end

  assign so = so_q;
`else
  assign so = 1'b0;
`endif

  assign dreq       = dreq_q;
  assign data_out   = mem_q[rp_q[AW-1:0]];
  assign data_valid = (wp_q != rp_q);
  assign mode       = regs_q[0];
  assign vol        = regs_q[11];
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_vs_spi_responder.sv
// Directed bench for vs_spi_responder: SCI vectors from a table plus hand-written
// SDI/flow-control/abort/reset sequences.
module tb_vs_spi_responder;

  logic        clk = 1'b0;
  logic        rst, xrset, xcs, xdcs, sclk, si, data_ready;
  logic        dreq, so, data_valid, frame_err, overflow;
  logic [15:0] data_out, mode, vol;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic [31:0] rx;

  typedef struct {
    logic [31:0] frame;
    logic [15:0] mode;
    logic [15:0] vol;
  } vec_t;
  vec_t vecs [6];

  vs_spi_responder dut (
    .clk(clk), .rst(rst), .xrset(xrset), .xcs(xcs), .xdcs(xdcs), .sclk(sclk), .si(si),
    .dreq(dreq), .so(so), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .mode(mode), .vol(vol), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // n bits MSB first, 4 clk low + 4 clk high per bit; so sampled just before each rise
  task automatic spi_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      si = val[i];
      repeat (4) @(negedge clk);
      rx = {rx[30:0], so};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic sci_frame(input logic [31:0] val);
    xcs = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(val, 32);
    repeat (4) @(negedge clk);
    xcs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int fe0;
    rst = 1'b1; xrset = 1'b1; xcs = 1'b1; xdcs = 1'b1; sclk = 1'b0; si = 1'b0;
    data_ready = 1'b0; rx = '0;

    vecs[0] = '{32'h020B2020, 16'h0800, 16'h2020};
    vecs[1] = '{32'h02000820, 16'h0820, 16'h2020};
    vecs[2] = '{32'h010BFFFF, 16'h0820, 16'h2020};
    vecs[3] = '{32'h021B5555, 16'h0820, 16'h2020};
    vecs[4] = '{32'h020BABCD, 16'h0820, 16'hABCD};
    vecs[5] = '{32'h030B0000, 16'h0820, 16'hABCD};

    // Reset state and boot delay
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_mode", 32'(mode), 32'h0800);
    chk("rst_vol", 32'(vol), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_so", 32'(so), 32'h0);
    repeat (63) @(posedge clk);
    #1 chk("boot_dreq_low", 32'(dreq), 32'h0);
    @(posedge clk);
    #1 chk("boot_dreq_high", 32'(dreq), 32'h1);
    @(negedge clk);

    // SCI register writes and discarded frames
    for (int i = 0; i < 6; i++) begin
      sci_frame(vecs[i].frame);
      chk($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].mode));
      chk($sformatf("vec%0d_vol", i), 32'(vol), 32'(vecs[i].vol));
    end
    chk("vec_no_frame_err", 32'(fe_cnt), 32'd0);

    // Soft reset flushes FIFO and restarts the boot delay
    xdcs = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(32'h0000AAAA, 16);
    spi_bits(32'h00005555, 16);
    repeat (4) @(negedge clk);
    xdcs = 1'b1;
    repeat (8) @(negedge clk);
    chk("sdi2_valid", 32'(data_valid), 32'h1);
    chk("sdi2_head", 32'(data_out), 32'h0000AAAA);
    sci_frame(32'h02000804);
    chk("srst_mode", 32'(mode), 32'h0800);
    chk("srst_vol", 32'(vol), 32'h0);
    chk("srst_valid", 32'(data_valid), 32'h0);
    chk("srst_dreq_low", 32'(dreq), 32'h0);
    repeat (70) @(negedge clk);
    chk("srst_dreq_high", 32'(dreq), 32'h1);

    // Aborted SCI frame after 20 bits
    fe0 = fe_cnt;
    xcs = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(32'h020B1111 >> 12, 20);
    repeat (4) @(negedge clk);
    xcs = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("abort_vol", 32'(vol), 32'h0);

    // Partial SDI word
    fe0 = fe_cnt;
    xdcs = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(32'h000000FF, 8);
    repeat (4) @(negedge clk);
    xdcs = 1'b1;
    repeat (8) @(negedge clk);
    chk("sdi_partial_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("sdi_partial_valid", 32'(data_valid), 32'h0);

    // xcs and xdcs both low: SCI wins, one frame_err
    fe0 = fe_cnt;
    xdcs = 1'b0;
    sci_frame(32'h020B4321);
    xdcs = 1'b1;
    repeat (8) @(negedge clk);
    chk("conflict_vol", 32'(vol), 32'h4321);
    chk("conflict_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("conflict_valid", 32'(data_valid), 32'h0);

    // Fill FIFO with 33 words, watch DREQ and overflow
    xdcs = 1'b0;
    repeat (4) @(negedge clk);
    for (int w = 0; w < 33; w++) begin
      spi_bits(32'(w), 16);
      repeat (2) @(negedge clk);
      if (w == 15) chk("fill16_dreq", 32'(dreq), 32'h1);
      if (w == 16) chk("fill17_dreq", 32'(dreq), 32'h0);
      if (w == 31) chk("fill32_ovf", 32'(overflow), 32'h0);
    end
    repeat (4) @(negedge clk);
    xdcs = 1'b1;
    repeat (8) @(negedge clk);
    chk("fill33_ovf", 32'(overflow), 32'h1);
    data_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("pop%0d_valid", i), 32'(data_valid), 32'h1);
      chk($sformatf("pop%0d_data", i), 32'(data_out), 32'(i));
      @(negedge clk);
    end
    data_ready = 1'b0;
    chk("drain_valid", 32'(data_valid), 32'h0);
    chk("drain_dreq", 32'(dreq), 32'h1);
    chk("drain_ovf_sticky", 32'(overflow), 32'h1);

    // SCI read of VOL
    sci_frame(32'h020B1234);
    rx = '0;
    sci_frame(32'h030B0000);
`ifdef SCI_READ_EN
    chk("read_vol_so", 32'(rx[15:0]), 32'h1234);
`else
    chk("read_vol_so", 32'(rx[15:0]), 32'h0000);
`endif
    chk("read_so_idle", 32'(so), 32'h0);
    chk("read_vol_kept", 32'(vol), 32'h1234);

    // Hardware reset via xrset
    xrset = 1'b0;
    repeat (6) @(negedge clk);
    chk("xrset_mode", 32'(mode), 32'h0800);
    chk("xrset_vol", 32'(vol), 32'h0);
    chk("xrset_ovf", 32'(overflow), 32'h0);
    chk("xrset_dreq", 32'(dreq), 32'h0);
    xrset = 1'b1;
    repeat (75) @(negedge clk);
    chk("xrset_dreq_high", 32'(dreq), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
